// File: rtl/sam8_sampler.sv
// Oversampling majority-vote sampler: it synchronises a slow, noisy serial line, counts the ones
// in each OVERSAMPLE-cycle window and emits one de-glitched bit per window, along with a divided sample clock.
module sam8_sampler #(
  parameter int OVERSAMPLE  = 8,
  parameter int HI_TH       = 5,
  parameter int LO_TH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic clkout,
  output logic out,
  output logic out_stb
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam int OW = $clog2(OVERSAMPLE + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] PHASE_HALF = PW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] HI_CNT     = OW'(HI_TH);
  localparam logic [OW-1:0] LO_CNT     = OW'(LO_TH);

  if (!(LO_TH < HI_TH && HI_TH <= OVERSAMPLE)) begin : g_bad_thresholds
    $error("sam8_sampler: require LO_TH < HI_TH <= OVERSAMPLE");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("sam8_sampler: OVERSAMPLE must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sam8_sampler: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [PW-1:0]          phase;
  logic [OW-1:0]          ones;
  logic [OW-1:0]          total;

  // NOTE: the chain resets to the idle level, so a line that is idle at release counts as idle rather than as a burst of zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // Adding the current sample makes the window exactly OVERSAMPLE samples. The count cannot exceed OVERSAMPLE.
  assign total = ones + OW'(s);

  // NOTE: non-blocking assignments let every register read the pre-edge values, so phase, ones and out stay in step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      ones    <= '0;
      clkout  <= 1'b0;
      out     <= IDLE_LEVEL;
      out_stb <= 1'b0;
    end else begin
      // High while the updated phase is 1..OVERSAMPLE/2, so clkout rises one clk after out updates.
      clkout <= (phase < PHASE_HALF);
      if (phase == PHASE_LAST) begin
        phase   <= '0;
        ones    <= '0;
        out_stb <= 1'b1;
        if (total >= HI_CNT) begin
          out <= 1'b1;
        end else if (total <= LO_CNT) begin
          out <= 1'b0;
        end
      end else begin
        phase   <= phase + 1'b1;
        ones    <= total;
        out_stb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sam8_sampler.sv
// Self-checking bench for sam8_sampler. A behavioural window model queues the expected bits,
// and directed tests cover reset, latency, thresholds, glitches and reset in the middle of a window.
module tb_sam8_sampler;

  localparam int OS = 8;
  localparam int HI = 5;
  localparam int LO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b1;
  logic clkout, out, out_stb;

  int n_cmp = 0;
  int n_err = 0;

  sam8_sampler dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
    .clkout (clkout),
    .out    (out),
    .out_stb(out_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: a two-stage delay line feeds the window count, and the expected bits go to exp_q.
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic m_out = 1'b1, m_out_prev = 1'b1, m_stb = 1'b0, m_clkout = 1'b0, m_clk_rise = 1'b0;
  logic nclk;
  int   m_phase = 0, m_ones = 0, ms, np, mt;
  logic exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_out = 1'b1; m_out_prev = 1'b1; m_stb = 1'b0;
      m_clkout = 1'b0; m_clk_rise = 1'b0;
      m_phase = 0; m_ones = 0;
      exp_q.delete();
    end else begin
      m_out_prev = m_out;
      ms   = int'(m_s2);
      m_s2 = m_s1;
      m_s1 = in;
      np   = (m_phase + 1) % OS;
      nclk = (np >= 1 && np <= OS / 2);
      m_clk_rise = nclk && !m_clkout;
      m_clkout   = nclk;
      if (m_phase == OS - 1) begin
        mt = m_ones + ms;
        if (mt >= HI) m_out = 1'b1;
        else if (mt <= LO) m_out = 1'b0;
        exp_q.push_back(m_out);
        m_ones = 0;
        m_stb  = 1'b1;
      end else begin
        m_ones = m_ones + ms;
        m_stb  = 1'b0;
      end
      m_phase = np;
    end
  end

  // Every cycle: compare against the model and check that out is stable at each clkout rise. Each strobe pops the scoreboard.
  always @(negedge clk) begin
    check("out", int'(out), int'(m_out));
    check("stb", int'(out_stb), int'(m_stb));
    check("clkout", int'(clkout), int'(m_clkout));
    if (m_clk_rise) check("out_pre_clk", int'(out), int'(m_out_prev));
    if (out_stb && exp_q.size() > 0) check("sb_out", int'(out), int'(exp_q.pop_front()));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the next edge will see the given phase. The wait is bounded by a cycle budget.
  task automatic align(input int ph);
    int k = 0;
    while (m_phase != ph && k < 4 * OS) begin
      @(negedge clk);
      k++;
    end
    if (m_phase != ph) check("align_timeout", m_phase, ph);
  endtask

  // Drive one window-aligned 8-bit pattern, then the fill level, and check the bit at the end of the window.
  task automatic window(input string tag, input logic [7:0] pat, input logic fill, input logic exp);
    align(OS - 2);
    for (int i = 0; i < OS; i++) begin
      in = pat[i];
      @(negedge clk);
    end
    in = fill;
    tick(2);
    check({tag, "_stb"}, int'(out_stb), 1);
    check({tag, "_out"}, int'(out), int'(exp));
  endtask

  initial begin
    int n_stb, n_hi, first_stb, cnt, g;

    // Reset state, then a constant 1 gives a strobe every 8 clks and a clkout that is 4 clks high and 4 low.
    tick(2);
    check("rst_out", int'(out), 1);
    check("rst_stb", int'(out_stb), 0);
    check("rst_clkout", int'(clkout), 0);
    rst = 1'b0;
    n_stb = 0; n_hi = 0; first_stb = 0;
    for (int c = 1; c <= 3 * OS; c++) begin
      @(negedge clk);
      if (out_stb) begin
        n_stb++;
        if (first_stb == 0) first_stb = c;
      end
      if (clkout) n_hi++;
    end
    check("t1_stb_count", n_stb, 3);
    check("t1_first_stb", first_stb, OS);
    check("t1_clkout_high", n_hi, 3 * OS / 2);
    check("t1_out", int'(out), 1);

    // A constant 0 after reset must reach out within 2+16 clks, and the change must coincide with the strobe.
    #1 rst = 1'b1;
    in = 1'b0;
    tick(2);
    rst = 1'b0;
    cnt = 0;
    while (out !== 1'b0 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    check("t2_latency_ok", int'(cnt <= 18), 1);
    check("t2_out", int'(out), 0);
    check("t2_stb", int'(out_stb), 1);

    // Thresholds: 5 ones set out, 4 ones hold it, 3 ones clear it.
    in = 1'b0;
    tick(2 * OS);
    window("t3_five",  8'b1011_0101, 1'b1, 1'b1);
    window("t3_hold1", 8'b1100_0011, 1'b1, 1'b1);
    window("t3_three", 8'b0100_1001, 1'b0, 1'b0);
    window("t3_hold0", 8'b0101_0101, 1'b0, 1'b0);

    // A one-clk low glitch in every window must never clear out.
    in = 1'b1;
    tick(3 * OS);
    for (int w = 0; w < 4; w++) begin
      g = $urandom_range(0, OS - 1);
      align(OS - 2);
      for (int i = 0; i < OS; i++) begin
        in = (i == g) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      in = 1'b1;
      tick(2);
      check("t4_glitch_out", int'(out), 1);
    end

    // Reset at phase 5 with a partial count of ones. The next window must start from zero.
    in = 1'b0;
    tick(3 * OS);
    check("t5_pre_out", int'(out), 0);
    align(OS - 1);
    in = 1'b1;
    align(5);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_out", int'(out), 1);
    check("t5_rst_stb", int'(out_stb), 0);
    check("t5_rst_clkout", int'(clkout), 0);
    tick(2);
    in = 1'b0;
    rst = 1'b0;
    cnt = 0;
    while (out_stb !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("t5_stb_delay", cnt, OS);
    check("t5_partial_discarded", int'(out), 0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
